ext_uart_responder: RTL and testbench



---
 rtl/ext_uart_responder.sv | 206 ++++++++++++++++++++
 tb/tb_ext_uart_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_uart_responder.sv
// Byte console on the extended bus: reads at RD_ADDR pop the RX holding register, writes at WR_ADDR feed an 8N1 TX FIFO.
// Start bit leaves one cycle after a push into an idle transmitter; ext_ready stalls reads while RX is empty and writes while the FIFO is full.
module ext_uart_responder #(
  parameter int          CLKS_PER_BIT  = 434,
  parameter int          TX_DEPTH_LOG2 = 2,
  parameter logic [19:0] RD_ADDR       = 20'h10100,
  parameter logic [19:0] WR_ADDR       = 20'h10200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] ext_addr,
  input  logic        ext_rw,
  input  logic        ext_strobe,
  input  logic [7:0]  ext_wdata,
  output logic [7:0]  ext_rdata,
  output logic        ext_ready,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int PW    = TX_DEPTH_LOG2 + 1;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_t        tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic          tx_q, tx_d;
  logic [1:0]    rx_sync_q, rx_sync_d;
  logic [7:0]    rx_hold_q, rx_hold_d;
  logic          rx_full_q, rx_full_d;

  logic rd_hit, wr_hit, rd_done, push, tx_pop, fifo_empty, fifo_full, rx_in, rx_byte_vld;

  assign rd_hit     = ext_strobe & ext_rw & (ext_addr == RD_ADDR);
  assign wr_hit     = ext_strobe & ~ext_rw & (ext_addr == WR_ADDR);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == PTR_FULL);
  assign ext_ready  = ~((rd_hit & ~rx_full_q) | (wr_hit & fifo_full));
  assign ext_rdata  = rd_hit ? rx_hold_q : 8'h00;
  assign rd_done    = rd_hit & rx_full_q;
  assign push       = wr_hit & ~fifo_full;
  assign uart_tx    = tx_q;
  assign rx_in      = rx_sync_q[1];
  assign rx_sync_d  = {rx_sync_q[0], uart_rx};

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[TX_DEPTH_LOG2-1:0]] = ext_wdata;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (tx_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Transmitter: the single IDLE cycle between frames is where the FIFO is popped.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = mem_q[rd_ptr_q[TX_DEPTH_LOG2-1:0]];
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_d       = tx_sh_q[0];
          tx_state_d = S_DATA;
        end else tx_cnt_d = tx_cnt_q + CNT_ONE;
      end
      S_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_d     = tx_sh_q[1];
          end
        end else tx_cnt_d = tx_cnt_q + CNT_ONE;
      end
      S_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_IDLE;
        end else tx_cnt_d = tx_cnt_q + CNT_ONE;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // Receiver: a framing error drops straight back to IDLE without waiting for the line to idle.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_byte_vld = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_in) begin
          rx_cnt_d   = '0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_in ? S_IDLE : S_DATA;
        end else rx_cnt_d = rx_cnt_q + CNT_ONE;
      end
      S_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_in, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q + CNT_ONE;
      end
      S_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d    = '0;
          rx_byte_vld = rx_in;
          rx_state_d  = S_IDLE;
        end else rx_cnt_d = rx_cnt_q + CNT_ONE;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // A read completing on the delivery edge frees the register for the new byte.
  always_comb begin
    rx_hold_d = rx_hold_q;
    rx_full_d = rx_full_q;
    if (rd_done) rx_full_d = 1'b0;
    if (rx_byte_vld && (!rx_full_q || rd_done)) begin
      rx_hold_d = rx_sh_q;
      rx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_sh_q    <= 8'h00;
      tx_q       <= 1'b1;
      rx_sync_q  <= 2'b11;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
      rx_hold_q  <= 8'h00;
      rx_full_q  <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_hold_q  <= rx_hold_d;
      rx_full_q  <= rx_full_d;
    end
  end

endmodule

// File: tb/tb_ext_uart_responder.sv
// Bench for ext_uart_responder at CLKS_PER_BIT=4, 4-entry TX FIFO; a line monitor decodes uart_tx frames independently.
module tb_ext_uart_responder;
  localparam int CPB = 4;
  localparam logic [19:0] RD = 20'h10100;
  localparam logic [19:0] WR = 20'h10200;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] ext_addr;
  logic        ext_rw, ext_strobe;
  logic [7:0]  ext_wdata, ext_rdata;
  logic        ext_ready, uart_rx, uart_tx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  logic [7:0] mon_bytes[$];
  int         mon_starts[$];
  bit         mon_bad[$];

  ext_uart_responder #(.CLKS_PER_BIT(CPB), .TX_DEPTH_LOG2(2), .RD_ADDR(RD), .WR_ADDR(WR)) dut (
    .clk(clk), .rst(rst), .ext_addr(ext_addr), .ext_rw(ext_rw), .ext_strobe(ext_strobe),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ready(ext_ready),
    .uart_rx(uart_rx), .uart_tx(uart_tx));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: 10 bits x CPB samples per frame, taken on the falling clock edge.
  initial begin
    logic prev;
    logic [39:0] s;
    bit abort, bad;
    int st;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && !uart_tx) begin
        st = cyc; s = '0; abort = 0;
        for (int k = 1; k < 40; k++) begin
          @(negedge clk);
          if (rst) abort = 1;
          s[k] = uart_tx;
        end
        if (!abort) begin
          bad = 0;
          for (int k = 0; k < CPB; k++) begin
            if (s[k] !== 1'b0) bad = 1;
            if (s[36+k] !== 1'b1) bad = 1;
          end
          for (int i = 0; i < 8; i++) begin
            b[i] = s[4*(i+1)];
            for (int k = 1; k < CPB; k++) if (s[4*(i+1)+k] !== b[i]) bad = 1;
          end
          mon_bytes.push_back(b); mon_starts.push_back(st); mon_bad.push_back(bad);
        end
      end
      prev = uart_tx;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    mon_bytes.delete(); mon_starts.delete(); mon_bad.delete();
  endtask

  task automatic bus_access(input logic rw, input logic [19:0] addr, input logic [7:0] wd, input int budget,
                            output logic [7:0] rd, output int stalls, output bit done, output logic first_rdy);
    ext_addr = addr; ext_rw = rw; ext_wdata = wd; ext_strobe = 1'b1;
    stalls = 0; done = 0; rd = 8'h00; first_rdy = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      #1;
      if (i == 0) first_rdy = ext_ready;
      if (ext_ready === 1'b1) begin rd = ext_rdata; done = 1; end
      else stalls++;
      @(posedge clk); #1;
    end
    ext_strobe = 1'b0;
    last_done_cyc = cyc;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 10; i++) begin
      uart_rx = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
      step(CPB);
    end
    uart_rx = 1'b1;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (mon_bytes.size() >= n) break;
      step(1);
    end
    if (mon_bytes.size() >= n) ok = 1;
  endtask

  task automatic test_reset();
    logic [7:0] rd; int st; bit dn; logic fr;
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
    checks++; if (ext_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", ext_rdata); end
    checks++; if (ext_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ext_ready); end
    rst = 1'b0;
    step(2);
    bus_access(1'b1, RD, 8'h00, 3, rd, st, dn, fr);
    checks++; if (dn !== 1'b0) begin failures++; $display("FAIL reset_rx_empty got=%b exp=0", dn); end
  endtask

  task automatic test_tx_single();
    logic [7:0] rd; int st; bit dn, ok; logic fr; int lat;
    clear_mon();
    bus_access(1'b0, WR, 8'h55, 10, rd, st, dn, fr);
    checks++; if (fr !== 1'b1) begin failures++; $display("FAIL tx1_ready got=%b exp=1", fr); end
    wait_frames(1, 80, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL tx1_frame_seen got=%b exp=1", ok); end
    if (ok) begin
      lat = mon_starts[0] - last_done_cyc;
      checks++; if (mon_bytes[0] !== 8'h55) begin failures++; $display("FAIL tx1_byte got=%h exp=55", mon_bytes[0]); end
      checks++; if (mon_bad[0] !== 1'b0) begin failures++; $display("FAIL tx1_bit_timing got=%b exp=0", mon_bad[0]); end
      checks++; if (lat < 0 || lat > 2) begin failures++; $display("FAIL tx1_latency got=%0d exp=0..2", lat); end
    end
    step(10);
    checks++; if (uart_tx !== 1'b1 || mon_bytes.size() != 1) begin
      failures++; $display("FAIL tx1_idle_after got=%b/%0d exp=1/1", uart_tx, mon_bytes.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; int st; bit dn, ok; logic fr;
    clear_mon();
    for (int i = 1; i <= 5; i++) begin
      bus_access(1'b0, WR, 8'(i), 100, rd, st, dn, fr);
      checks++; if (dn !== 1'b1) begin failures++; $display("FAIL b2b_write%0d got=%b exp=1", i, dn); end
    end
    bus_access(1'b0, WR, 8'h06, 200, rd, st, dn, fr);
    checks++; if (fr !== 1'b0) begin failures++; $display("FAIL b2b_full_stall got=%b exp=0", fr); end
    checks++; if (dn !== 1'b1 || st < 30) begin failures++; $display("FAIL b2b_full_release got=%b/%0d exp=1/>=30", dn, st); end
    wait_frames(6, 400, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL b2b_frames got=%0d exp=6", mon_bytes.size()); end
    if (ok) begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (mon_bytes[i] !== 8'(i + 1) || mon_bad[i]) begin
          failures++; $display("FAIL b2b_byte%0d got=%h/%b exp=%h/0", i, mon_bytes[i], mon_bad[i], 8'(i + 1)); end
      end
      for (int i = 1; i < 6; i++) begin
        checks++; if (mon_starts[i] - mon_starts[i-1] != 10 * CPB + 1) begin
          failures++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", i, mon_starts[i] - mon_starts[i-1], 10 * CPB + 1); end
      end
    end
  endtask

  task automatic test_rx_read();
    bit found;
    ext_addr = RD; ext_rw = 1'b1; ext_strobe = 1'b1;
    #1;
    checks++; if (ext_ready !== 1'b0) begin failures++; $display("FAIL rx_empty_stall got=%b exp=0", ext_ready); end
    send_frame(8'hA3, 1'b1);
    found = 0;
    for (int i = 0; i < 12; i++) begin
      if (ext_ready === 1'b1) begin found = 1; break; end
      step(1);
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL rx_ready_rise got=%b exp=1", found); end
    checks++; if (ext_rdata !== 8'hA3) begin failures++; $display("FAIL rx_data got=%h exp=a3", ext_rdata); end
    step(1);
    #1;
    checks++; if (ext_ready !== 1'b0) begin failures++; $display("FAIL rx_pop_once got=%b exp=0", ext_ready); end
    ext_strobe = 1'b0;
    step(1);
  endtask

  task automatic test_rx_errors();
    logic [7:0] rd; int st; bit dn; logic fr; logic [7:0] b;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    step(4);
    bus_access(1'b1, RD, 8'h00, 4, rd, st, dn, fr);
    checks++; if (dn !== 1'b1 || rd !== 8'h11) begin failures++; $display("FAIL rx_overrun_keep got=%b/%h exp=1/11", dn, rd); end
    bus_access(1'b1, RD, 8'h00, 3, rd, st, dn, fr);
    checks++; if (dn !== 1'b0) begin failures++; $display("FAIL rx_overrun_drop got=%b exp=0", dn); end
    uart_rx = 1'b0; step(1); uart_rx = 1'b1; step(20);
    bus_access(1'b1, RD, 8'h00, 3, rd, st, dn, fr);
    checks++; if (dn !== 1'b0) begin failures++; $display("FAIL rx_glitch got=%b exp=0", dn); end
    send_frame(8'h7E, 1'b0);
    step(20);
    bus_access(1'b1, RD, 8'h00, 3, rd, st, dn, fr);
    checks++; if (dn !== 1'b0) begin failures++; $display("FAIL rx_framing got=%b exp=0", dn); end
    b = 8'($urandom);
    send_frame(b, 1'b1);
    step(4);
    bus_access(1'b1, RD, 8'h00, 4, rd, st, dn, fr);
    checks++; if (dn !== 1'b1 || rd !== b) begin failures++; $display("FAIL rx_recover got=%b/%h exp=1/%h", dn, rd, b); end
  endtask

  task automatic test_decode();
    logic [7:0] rd; int st; bit dn; logic fr;
    logic [19:0] addrs [6];
    logic        rws   [6];
    addrs = '{20'h0F7FE, 20'h0F7FE, 20'h10101, 20'h10101, RD, WR};
    rws   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    send_frame(8'h5A, 1'b1);
    step(4);
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      bus_access(rws[i], addrs[i], 8'($urandom), 3, rd, st, dn, fr);
      checks++; if (fr !== 1'b1 || (rws[i] && rd !== 8'h00)) begin
        failures++; $display("FAIL decode%0d got=%b/%h exp=1/00", i, fr, rd); end
    end
    step(50);
    checks++; if (mon_bytes.size() != 0) begin failures++; $display("FAIL decode_no_tx got=%0d exp=0", mon_bytes.size()); end
    bus_access(1'b1, RD, 8'h00, 3, rd, st, dn, fr);
    checks++; if (dn !== 1'b1 || rd !== 8'h5A) begin failures++; $display("FAIL decode_hold got=%b/%h exp=1/5a", dn, rd); end
  endtask

  task automatic test_random();
    logic [7:0] rd; int st; bit dn, ok; logic fr;
    logic [7:0] exp_q[$];
    logic [7:0] b, m_val;
    bit m_full, good;
    int n;
    clear_mon();
    n = $urandom_range(3, 8);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 50));
      b = 8'($urandom);
      bus_access(1'b0, WR, b, 300, rd, st, dn, fr);
      checks++; if (dn !== 1'b1) begin failures++; $display("FAIL rnd_tx_write%0d got=%b exp=1", i, dn); end
      if (dn) exp_q.push_back(b);
    end
    wait_frames(exp_q.size(), 600, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rnd_tx_count got=%0d exp=%0d", mon_bytes.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < mon_bytes.size(); i++) begin
      checks++; if (mon_bytes[i] !== exp_q[i] || mon_bad[i]) begin
        failures++; $display("FAIL rnd_tx_byte%0d got=%h/%b exp=%h/0", i, mon_bytes[i], mon_bad[i], exp_q[i]); end
    end
    m_full = 0; m_val = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      send_frame(b, good);
      step(6);
      if (good && !m_full) begin m_full = 1; m_val = b; end
      if ($urandom_range(0, 1) == 1 || i == 7) begin
        bus_access(1'b1, RD, 8'h00, 4, rd, st, dn, fr);
        checks++; if (dn !== m_full || (m_full && rd !== m_val)) begin
          failures++; $display("FAIL rnd_rx%0d got=%b/%h exp=%b/%h", i, dn, rd, m_full, m_val); end
        m_full = 0;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rd; int st; bit dn; logic fr; bit fell, stayed_high;
    clear_mon();
    bus_access(1'b0, WR, 8'hC6, 10, rd, st, dn, fr);
    fell = 0;
    for (int i = 0; i < 10; i++) begin
      if (uart_tx === 1'b0) begin fell = 1; break; end
      step(1);
    end
    checks++; if (fell !== 1'b1) begin failures++; $display("FAIL rstmid_start got=%b exp=1", fell); end
    bus_access(1'b0, WR, 8'h3C, 10, rd, st, dn, fr);
    bus_access(1'b0, WR, 8'h99, 10, rd, st, dn, fr);
    step(4 * CPB - 1);
    checks++; if (uart_tx !== 1'b0) begin failures++; $display("FAIL rstmid_bit3 got=%b exp=0", uart_tx); end
    rst = 1'b1;
    #1;
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL rstmid_async_tx got=%b exp=1", uart_tx); end
    step(2);
    rst = 1'b0;
    stayed_high = 1;
    for (int i = 0; i < 80; i++) begin
      step(1);
      if (uart_tx !== 1'b1) stayed_high = 0;
    end
    checks++; if (stayed_high !== 1'b1 || mon_bytes.size() != 0) begin
      failures++; $display("FAIL rstmid_line_idle got=%b/%0d exp=1/0", stayed_high, mon_bytes.size()); end
    bus_access(1'b1, RD, 8'h00, 3, rd, st, dn, fr);
    checks++; if (dn !== 1'b0) begin failures++; $display("FAIL rstmid_rx_empty got=%b exp=0", dn); end
  endtask

  initial begin
    rst = 1'b1; ext_addr = '0; ext_rw = 1'b0; ext_strobe = 1'b0; ext_wdata = '0; uart_rx = 1'b1;
    step(3);
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx_read();
    test_rx_errors();
    test_decode();
    test_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
